// File: rtl/conv_enc_frame_ctrl_if.sv
// Stream bundle for the convolutional encoder: word input side (s_*) and
// parity-pair output side (m_*).
interface conv_enc_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [1:0]        m_parity;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_parity, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_parity, m_valid, m_last
  );
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Rate-1/2, constraint-length-3 convolutional encoder with word framing:
// serialises words MSB first and appends two zero tail bits after the last word.
module conv_enc_frame_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  conv_enc_frame_ctrl_if.slave   bus,
  output logic                   busy,
  output logic [15:0]            frame_count
);
  localparam int                IDX_W    = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
  // Generator taps over {bit, s[1], s[0]}: parity[0] = 110, parity[1] = 111.
  localparam logic [5:0]        GEN_POLY = 6'b111_110;

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t            state_reg;
  logic [1:0]        trellis_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              last_flag_reg;
  logic [15:0]       frame_count_reg;
  logic              s_ready_reg;
  logic              m_valid_reg;
  logic              m_last_reg;
  logic              busy_reg;

  logic              cur_bit;
  logic              beat_xfer;
  logic [2:0]        tap_vec;
  logic [1:0]        parity_w;

  assign cur_bit   = (state_reg == SHIFT) ? shift_reg[DATA_W-1] : 1'b0;
  assign beat_xfer = m_valid_reg && bus.m_ready;
  assign tap_vec   = {cur_bit, trellis_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_parity
    assign parity_w[gi] = ^(tap_vec & GEN_POLY[gi*3 +: 3]);
  end

  assign bus.s_ready  = s_ready_reg;
  assign bus.m_valid  = m_valid_reg;
  assign bus.m_last   = m_last_reg;
  assign bus.m_parity = m_valid_reg ? parity_w : 2'b00;
  assign busy         = busy_reg;
  assign frame_count  = frame_count_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      trellis_reg     <= 2'b00;
      shift_reg       <= '0;
      idx_reg         <= '0;
      last_flag_reg   <= 1'b0;
      frame_count_reg <= 16'h0000;
      s_ready_reg     <= 1'b0;
      m_valid_reg     <= 1'b0;
      m_last_reg      <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      // Trellis moves only when a beat is actually taken downstream.
      if (beat_xfer) begin
        trellis_reg <= {trellis_reg[0], cur_bit};
      end
      case (state_reg)
        IDLE: begin
          s_ready_reg <= 1'b1;
          if (bus.s_valid && s_ready_reg) begin
            shift_reg     <= bus.s_data;
            last_flag_reg <= bus.s_last;
            idx_reg       <= '0;
            state_reg     <= SHIFT;
            s_ready_reg   <= 1'b0;
            m_valid_reg   <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        SHIFT: begin
          if (beat_xfer) begin
            shift_reg <= shift_reg << 1;
            if (idx_reg == LAST_IDX) begin
              idx_reg <= '0;
              if (last_flag_reg) begin
                state_reg <= TAIL;
              end else begin
                // Trellis is kept so the next word continues the same code stream.
                state_reg   <= IDLE;
                s_ready_reg <= 1'b1;
                m_valid_reg <= 1'b0;
                busy_reg    <= 1'b0;
              end
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        TAIL: begin
          if (beat_xfer) begin
            if (m_last_reg) begin
              state_reg       <= IDLE;
              s_ready_reg     <= 1'b1;
              m_valid_reg     <= 1'b0;
              m_last_reg      <= 1'b0;
              busy_reg        <= 1'b0;
              frame_count_reg <= frame_count_reg + 16'd1;
            end else begin
              m_last_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Bench for conv_enc_frame_ctrl: an 8-bit and a 1-bit instance checked every cycle
// against a queue-based encoder model, plus literal beat sequences.
module tb_conv_enc_frame_ctrl;
  typedef struct packed {
    logic [1:0] par;
    logic       last;
  } beat_t;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        busy0, busy1;
  logic [15:0] fc0, fc1;

  int n_checks = 0;
  int n_errors = 0;

  conv_enc_frame_ctrl_if #(.DATA_W(8)) b0 ();
  conv_enc_frame_ctrl_if #(.DATA_W(1)) b1 ();

  conv_enc_frame_ctrl #(.DATA_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(b0), .busy(busy0), .frame_count(fc0)
  );
  conv_enc_frame_ctrl #(.DATA_W(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(b1), .busy(busy1), .frame_count(fc1)
  );

  always #5 CLK = ~CLK;

  // Parity pair indexed by {state, bit}, taken straight from the trellis table.
  logic [1:0]  par_tbl [8] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
  logic [15:0] wrap_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  beat_t       q0[$], q1[$], log0[$], log1[$];
  logic [1:0]  ms0 = 2'b00, ms1 = 2'b00;
  logic [15:0] exp_fc0 = 16'h0, exp_fc1 = 16'h0;
  logic        ev0, ev1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input int inst, input logic [31:0] w, input int nbits, input logic l);
    int    total;
    logic  b;
    logic [1:0] s;
    beat_t bt;
    total = l ? nbits + 2 : nbits;
    s = (inst == 0) ? ms0 : ms1;
    for (int k = 0; k < total; k++) begin
      b       = (k < nbits) ? w[nbits-1-k] : 1'b0;
      bt.par  = par_tbl[{s, b}];
      bt.last = l && (k == total - 1);
      s       = {s[0], b};
      if (inst == 0) q0.push_back(bt);
      else           q1.push_back(bt);
    end
    if (inst == 0) ms0 = s;
    else           ms1 = s;
  endtask

  // One compare process for both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      ev0 = (q0.size() != 0);
      check("m_valid0", {31'b0, b0.m_valid}, {31'b0, ev0});
      check("busy0", {31'b0, busy0}, {31'b0, ev0});
      check("frame_count0", {16'b0, fc0}, {16'b0, exp_fc0});
      if (ev0 && b0.m_valid) begin
        check("m_parity0", {30'b0, b0.m_parity}, {30'b0, q0[0].par});
        check("m_last0", {31'b0, b0.m_last}, {31'b0, q0[0].last});
        if (b0.m_ready) begin
          log0.push_back('{par: b0.m_parity, last: b0.m_last});
          if (q0[0].last) exp_fc0 = exp_fc0 + 16'd1;
          void'(q0.pop_front());
        end
      end
      ev1 = (q1.size() != 0);
      check("m_valid1", {31'b0, b1.m_valid}, {31'b0, ev1});
      check("busy1", {31'b0, busy1}, {31'b0, ev1});
      check("frame_count1", {16'b0, fc1}, {16'b0, exp_fc1});
      if (ev1 && b1.m_valid) begin
        check("m_parity1", {30'b0, b1.m_parity}, {30'b0, q1[0].par});
        check("m_last1", {31'b0, b1.m_last}, {31'b0, q1[0].last});
        if (b1.m_ready) begin
          log1.push_back('{par: b1.m_parity, last: b1.m_last});
          if (q1[0].last) exp_fc1 = exp_fc1 + 16'd1;
          void'(q1.pop_front());
        end
      end
    end
  end

  task automatic send0(input logic [7:0] d, input logic l, input int extra);
    int n = 0;
    @(posedge CLK); #1;
    b0.s_data = d; b0.s_last = l; b0.s_valid = 1'b1;
    while (n < 100) begin
      @(negedge CLK);
      if (b0.s_ready) break;
      n++;
    end
    check("accept_timeout0", {31'b0, n < 100}, 32'd1);
    @(posedge CLK); #1;
    model_push(0, {24'b0, d}, 8, l);
    $display("dut8 word %h last %b accepted at %0t", d, l, $time);
    b0.s_data = ~d; b0.s_last = ~l;
    repeat (extra) begin @(posedge CLK); #1; end
    b0.s_valid = 1'b0;
  endtask

  task automatic send1(input logic d, input logic l, input int extra);
    int n = 0;
    @(posedge CLK); #1;
    b1.s_data = d; b1.s_last = l; b1.s_valid = 1'b1;
    while (n < 100) begin
      @(negedge CLK);
      if (b1.s_ready) break;
      n++;
    end
    check("accept_timeout1", {31'b0, n < 100}, 32'd1);
    @(posedge CLK); #1;
    model_push(1, {31'b0, d}, 1, l);
    $display("dut1 word %b last %b accepted at %0t", d, l, $time);
    b1.s_data = ~d; b1.s_last = ~l;
    repeat (extra) begin @(posedge CLK); #1; end
    b1.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int inst);
    int n = 0;
    while (n < 300) begin
      if (inst == 0 && q0.size() == 0 && !b0.m_valid) break;
      if (inst == 1 && q1.size() == 0 && !b1.m_valid) break;
      @(negedge CLK);
      n++;
    end
    check("done_timeout", {31'b0, n < 300}, 32'd1);
  endtask

  task automatic check_seq(input string name, input beat_t lg[$], input logic [63:0] pv, input int nb);
    logic [1:0] ep;
    check({name, "_len"}, lg.size(), nb);
    for (int k = 0; k < nb && k < lg.size(); k++) begin
      ep = pv[2*(nb-1-k) +: 2];
      check($sformatf("%s_par%0d", name, k), {30'b0, lg[k].par}, {30'b0, ep});
      check($sformatf("%s_last%0d", name, k), {31'b0, lg[k].last}, {31'b0, k == nb - 1});
    end
  endtask

  task automatic flush_models();
    q0.delete(); q1.delete(); log0.delete(); log1.delete();
    ms0 = 2'b00; ms1 = 2'b00; exp_fc0 = 16'h0; exp_fc1 = 16'h0;
  endtask

  initial begin
    b0.s_valid = 1'b0; b0.s_data = '0; b0.s_last = 1'b0; b0.m_ready = 1'b1;
    b1.s_valid = 1'b0; b1.s_data = '0; b1.s_last = 1'b0; b1.m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_s_ready", {31'b0, b0.s_ready}, 32'd0);
    check("rst_m_valid", {31'b0, b0.m_valid}, 32'd0);
    check("rst_m_last", {31'b0, b0.m_last}, 32'd0);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_m_parity", {30'b0, b0.m_parity}, 32'd0);
    check("rst_frame_count", {16'b0, fc0}, 32'd0);
    check("rst_frame_count1", {16'b0, fc1}, 32'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("release_s_ready", {31'b0, b0.s_ready}, 32'd1);
    check("release_s_ready1", {31'b0, b1.s_ready}, 32'd1);

    // Reset pulsed during beat 5 drops the partial frame
    send0(8'hB0, 1'b1, 0);
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    flush_models();
    @(negedge CLK);
    check("midrst_m_valid", {31'b0, b0.m_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy0}, 32'd0);
    check("midrst_m_last", {31'b0, b0.m_last}, 32'd0);
    check("midrst_m_parity", {30'b0, b0.m_parity}, 32'd0);
    check("midrst_frame_count", {16'b0, fc0}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_s_ready", {31'b0, b0.s_ready}, 32'd1);

    // Single word frame B0
    log0.delete();
    send0(8'hB0, 1'b1, 0);
    wait_done(0);
    check_seq("b0", log0, 64'b11100001011100000000, 10);
    check("b0_frame_count", {16'b0, fc0}, 32'd1);

    // Same frame with a 3-cycle stall on beat 4
    log0.delete();
    send0(8'hB0, 1'b1, 0);
    repeat (3) @(posedge CLK);
    #1 b0.m_ready = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("stall_hold_par", {30'b0, b0.m_parity}, 32'd1);
      check("stall_hold_valid", {31'b0, b0.m_valid}, 32'd1);
    end
    @(posedge CLK); #1 b0.m_ready = 1'b1;
    wait_done(0);
    check_seq("b0_stall", log0, 64'b11100001011100000000, 10);
    check("stall_frame_count", {16'b0, fc0}, 32'd2);

    // Two-word frame: trellis carries across the word boundary
    log0.delete();
    send0(8'hFF, 1'b0, 0);
    send0(8'h00, 1'b1, 0);
    wait_done(0);
    check_seq("ff00", log0, 64'b110110101010101001110000000000000000, 18);
    check("ff00_frame_count", {16'b0, fc0}, 32'd3);

    // Word 01 with s_valid held into SHIFT (must be ignored)
    log0.delete();
    send0(8'h01, 1'b1, 3);
    wait_done(0);
    check_seq("w01", log0, 64'b00000000000000111011, 10);
    check("w01_frame_count", {16'b0, fc0}, 32'd4);

    // Three-word frame with m_ready toggling
    send0(8'h5A, 1'b0, 0);
    send0(8'hC3, 1'b0, 2);
    send0(8'h96, 1'b1, 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1 b0.m_ready = k[0];
    end
    b0.m_ready = 1'b1;
    wait_done(0);
    check("multi_frame_count", {16'b0, fc0}, 32'd5);

    // DATA_W=1: one beat per word, then the tail
    log1.delete();
    send1(1'b1, 1'b1, 1);
    wait_done(1);
    check_seq("w1", log1, 64'b111011, 3);
    send1(1'b1, 1'b0, 1);
    send1(1'b1, 1'b1, 1);
    wait_done(1);
    for (int k = 0; k < 4; k++) begin
      send1(k[0], 1'b1, 1);
      wait_done(1);
    end
    check("w1_frame_count", {16'b0, fc1}, 32'd6);

    // Preload near the top of the counter and run through the wrap
    @(posedge CLK); #1;
    force dut1.frame_count_reg = 16'hFFFD;
    exp_fc1 = 16'hFFFD;
    #1 release dut1.frame_count_reg;
    for (int k = 0; k < 4; k++) begin
      send1(k[1], 1'b1, 1);
      wait_done(1);
      check($sformatf("wrap_count%0d", k), {16'b0, fc1}, {16'b0, wrap_exp[k]});
    end

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not complete within 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
